// File: rtl/fpaa_prog_sequencer.sv
// Floating-gate programming sequencer: one inject/tunnel/measure op per command, address->pulse->hold->done.
// Optional abort input enabled by defining FPAA_PROG_ABORT_EN.
module fpaa_prog_sequencer #(
  parameter int unsigned ROW_BITS   = 6,
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned NUM_ROWS   = 48,
  parameter int unsigned NUM_COLS   = 52,
  parameter int unsigned PW_BITS    = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef FPAA_PROG_ABORT_EN
  input  logic                abort,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [PW_BITS-1:0]  cmd_pulse,
  output logic [ROW_BITS-1:0] dec_row,
  output logic [COL_BITS-1:0] dec_col,
  output logic                dec_en,
  output logic                prog_r,
  output logic                run_r,
  output logic                drain_en,
  output logic                vtun_en,
  output logic                meas_win,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_INJECT  = 2'b00;
  localparam logic [1:0] OP_TUNNEL  = 2'b01;
  localparam logic [1:0] OP_MEASURE = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [PW_BITS-1:0] SETTLE_LAST = PW_BITS'(SETTLE_CYC - 1);

  logic [2:0]          state_q, state_d;
  logic [PW_BITS-1:0]  cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [PW_BITS-1:0]  pulse_q, pulse_d;
  logic                bad_q, bad_d;

  logic [ROW_BITS-1:0] dec_row_q, dec_row_d;
  logic [COL_BITS-1:0] dec_col_q, dec_col_d;
  logic dec_en_q, dec_en_d, prog_r_q, prog_r_d, run_r_q, run_r_d;
  logic drain_en_q, drain_en_d, vtun_en_q, vtun_en_d, meas_win_q, meas_win_d;
  logic done_q, done_d, err_q, err_d;

  logic abort_w;
  logic cmd_illegal;

`ifdef FPAA_PROG_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign cmd_illegal = (cmd_op == OP_RSVD) || (cmd_pulse == '0) ||
                       (32'(cmd_row) >= NUM_ROWS) || (32'(cmd_col) >= NUM_COLS);

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    row_d   = row_q;
    col_d   = col_q;
    pulse_d = pulse_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          row_d   = cmd_row;
          col_d   = cmd_col;
          pulse_d = cmd_pulse;
          bad_d   = cmd_illegal;
          cnt_d   = SETTLE_LAST;
          state_d = cmd_illegal ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (abort_w) begin
          state_d = ST_HOLD;
          cnt_d   = SETTLE_LAST;
          bad_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = pulse_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (abort_w) begin
          state_d = ST_HOLD;
          cnt_d   = SETTLE_LAST;
          bad_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = SETTLE_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    dec_row_d  = '0;
    dec_col_d  = '0;
    dec_en_d   = 1'b0;
    prog_r_d   = 1'b0;
    run_r_d    = 1'b1;
    drain_en_d = 1'b0;
    vtun_en_d  = 1'b0;
    meas_win_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (state_d inside {ST_ADDR, ST_PULSE, ST_HOLD}) begin
      dec_row_d = row_d;
      dec_col_d = col_d;
      dec_en_d  = 1'b1;
      prog_r_d  = 1'b1;
      run_r_d   = 1'b0;
    end
    if (state_d == ST_PULSE) begin
      case (op_d)
        OP_INJECT:  drain_en_d = 1'b1;
        OP_TUNNEL:  vtun_en_d  = 1'b1;
        OP_MEASURE: begin
          drain_en_d = 1'b1;
          meas_win_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
      err_d  = bad_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_INJECT;
      row_q      <= '0;
      col_q      <= '0;
      pulse_q    <= '0;
      bad_q      <= 1'b0;
      dec_row_q  <= '0;
      dec_col_q  <= '0;
      dec_en_q   <= 1'b0;
      prog_r_q   <= 1'b0;
      run_r_q    <= 1'b1;
      drain_en_q <= 1'b0;
      vtun_en_q  <= 1'b0;
      meas_win_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pulse_q    <= pulse_d;
      bad_q      <= bad_d;
      dec_row_q  <= dec_row_d;
      dec_col_q  <= dec_col_d;
      dec_en_q   <= dec_en_d;
      prog_r_q   <= prog_r_d;
      run_r_q    <= run_r_d;
      drain_en_q <= drain_en_d;
      vtun_en_q  <= vtun_en_d;
      meas_win_q <= meas_win_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign dec_row   = dec_row_q;
  assign dec_col   = dec_col_q;
  assign dec_en    = dec_en_q;
  assign prog_r    = prog_r_q;
  assign run_r     = run_r_q;
  assign drain_en  = drain_en_q;
  assign vtun_en   = vtun_en_q;
  assign meas_win  = meas_win_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
